wb_arbiter_2m: RTL and testbench

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

---
 rtl/wb_arbiter_2m.sv | 191 +++++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter (m0 = core, m1 = debug/DMA)
// onto a single downstream bus.
//
// - The owner is held while that master keeps cyc high. There is no preemption.
// - Every handover passes through at least one IDLE cycle.
// - When both masters request from IDLE, the master not granted most recently
//   wins. After reset, m0 wins.
//
// Optional feature, selected with the macro ARB_TIMEOUT_EN:
// - A wait-state watchdog counts stalled cycles.
// - When the count reaches TIMEOUT_CYCLES, the next cycle terminates the
//   transfer. In that cycle bus cyc/stb are forced low, and the owner gets an
//   ack with read data 32'hFFFF_FFFF.
// - timeout_flag is then set sticky until reset.
//
// Handshake: an ack to a master means its current strobe is complete in this
// cycle. The master may present a new strobe, drop stb, or drop cyc at the
// next edge. The owner field is the FSM state itself, for observability.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (core)
  input  logic        m0__cyc,
  input  logic        m0__stb,
  input  logic        m0__we,
  input  logic [29:0] m0__adr,
  input  logic [3:0]  m0__sel,
  input  logic [31:0] m0__dat_w,
  output logic [31:0] m0__dat_r,
  output logic        m0__ack,
  // master 1 (debug/DMA)
  input  logic        m1__cyc,
  input  logic        m1__stb,
  input  logic        m1__we,
  input  logic [29:0] m1__adr,
  input  logic [3:0]  m1__sel,
  input  logic [31:0] m1__dat_w,
  output logic [31:0] m1__dat_r,
  output logic        m1__ack,
  // downstream bus
  output logic        bus__cyc,
  output logic        bus__stb,
  output logic        bus__we,
  output logic [29:0] bus__adr,
  output logic [3:0]  bus__sel,
  output logic [31:0] bus__dat_w,
  input  logic [31:0] bus__dat_r,
  input  logic        bus__ack,
  // status
  output logic [1:0]  owner,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  // 1 when m1 was granted most recently; reset value gives m0 priority.
  logic   last_q, last_d;
  // High in the cycle the watchdog terminates a stalled transfer.
  logic   tmo_hit;

  // State register and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate from IDLE, hold a grant while the owner keeps cyc.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0__cyc && m1__cyc) begin
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (m0__cyc) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1__cyc) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!m0__cyc) state_d = IDLE;
      GNT1:    if (!m1__cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: route the owner to the bus, steer ack/data back to it.
  always_comb begin
    bus__cyc   = 1'b0;
    bus__stb   = 1'b0;
    bus__we    = 1'b0;
    bus__adr   = '0;
    bus__sel   = '0;
    bus__dat_w = '0;
    m0__ack    = 1'b0;
    m1__ack    = 1'b0;
    m0__dat_r  = bus__dat_r;
    m1__dat_r  = bus__dat_r;
    if (state_q == GNT0) begin
      bus__cyc   = m0__cyc;
      bus__stb   = m0__stb;
      bus__we    = m0__we;
      bus__adr   = m0__adr;
      bus__sel   = m0__sel;
      bus__dat_w = m0__dat_w;
      m0__ack    = (bus__ack & m0__cyc & m0__stb) | tmo_hit;
      if (tmo_hit) m0__dat_r = 32'hFFFF_FFFF;
    end else if (state_q == GNT1) begin
      bus__cyc   = m1__cyc;
      bus__stb   = m1__stb;
      bus__we    = m1__we;
      bus__adr   = m1__adr;
      bus__sel   = m1__sel;
      bus__dat_w = m1__dat_w;
      m1__ack    = (bus__ack & m1__cyc & m1__stb) | tmo_hit;
      if (tmo_hit) m1__dat_r = 32'hFFFF_FFFF;
    end
    if (tmo_hit) begin
      bus__cyc = 1'b0;
      bus__stb = 1'b0;
    end
  end

  assign owner = state_q;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       own_cyc, own_stb;

  assign own_cyc = (state_q == GNT0) ? m0__cyc : (state_q == GNT1) ? m1__cyc : 1'b0;
  assign own_stb = (state_q == GNT0) ? m0__stb : (state_q == GNT1) ? m1__stb : 1'b0;
  assign tmo_hit = own_cyc & own_stb & (cnt_q == TmoLimit);

  // Wait-state count: runs on stalled strobes, restarts on any completion.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q | tmo_hit;
    if (!own_cyc || bus__ack || tmo_hit) begin
      cnt_d = '0;
    end else if (own_stb) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Watchdog counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  // The flag is visible already in the terminating cycle.
  assign timeout_flag = flag_q | tmo_hit;
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;

  // TIMEOUT_CYCLES only matters with the watchdog built in.
  // This range test keeps the parameter referenced in this build.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_out_of_range
  end
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m.
//
// Drivers issue Wishbone transactions per master and push the expected
// completion into a per-master queue. A monitor pops an entry on every master
// ack and compares it.
//
// An owner model, built from the arbitration rules, predicts the owner each
// cycle:
// - at most one IDLE gap between owners;
// - the loser from IDLE is the master granted most recently;
// - no preemption.
//
// The slave responds with random wait states.
module tb_wb_arbiter_2m;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0__cyc, m0__stb, m0__we, m1__cyc, m1__stb, m1__we;
  logic [29:0] m0__adr, m1__adr, bus__adr;
  logic [3:0]  m0__sel, m1__sel, bus__sel;
  logic [31:0] m0__dat_w, m1__dat_w, m0__dat_r, m1__dat_r, bus__dat_w, bus__dat_r;
  logic        m0__ack, m1__ack, bus__cyc, bus__stb, bus__we, bus__ack;
  logic [1:0]  owner;
  logic        timeout_flag;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0__cyc(m0__cyc), .m0__stb(m0__stb), .m0__we(m0__we), .m0__adr(m0__adr),
    .m0__sel(m0__sel), .m0__dat_w(m0__dat_w), .m0__dat_r(m0__dat_r), .m0__ack(m0__ack),
    .m1__cyc(m1__cyc), .m1__stb(m1__stb), .m1__we(m1__we), .m1__adr(m1__adr),
    .m1__sel(m1__sel), .m1__dat_w(m1__dat_w), .m1__dat_r(m1__dat_r), .m1__ack(m1__ack),
    .bus__cyc(bus__cyc), .bus__stb(bus__stb), .bus__we(bus__we), .bus__adr(bus__adr),
    .bus__sel(bus__sel), .bus__dat_w(bus__dat_w), .bus__dat_r(bus__dat_r), .bus__ack(bus__ack),
    .owner(owner), .timeout_flag(timeout_flag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int slave_mute = 0;
  int slave_fix = 0;
  bit skip_bus = 1'b0;
  logic [66:0] exp0_q[$];
  logic [66:0] exp1_q[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rd_data(input logic [29:0] a);
    return (a == 30'h100) ? 32'hDEAD_BEEF : ({a, 2'b00} ^ 32'h5A5A_C3C3);
  endfunction

  function automatic logic ack_of(input int id);
    return (id == 0) ? m0__ack : m1__ack;
  endfunction

  // ---------------- slave model ----------------
  initial begin
    logic        act;
    logic [29:0] a;
    int          waits;
    int          tgt;
    bus__ack   = 1'b0;
    bus__dat_r = '0;
    waits      = 0;
    tgt        = 1;
    forever begin
      @(negedge clk);
      act = bus__cyc && bus__stb;
      a   = bus__adr;
      @(posedge clk);
      #1;
      if (rst) begin
        bus__ack = 1'b0;
        waits    = 0;
      end else if (bus__ack) begin
        bus__ack   = 1'b0;
        bus__dat_r = $urandom;
        waits      = 0;
      end else if (act && slave_mute == 0) begin
        if (waits == 0) tgt = (slave_fix != 0) ? slave_fix : $urandom_range(1, 3);
        waits++;
        if (waits >= tgt) begin
          bus__ack   = 1'b1;
          bus__dat_r = rd_data(a);
        end
      end else if (!act) begin
        waits = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_m(input int id, input logic c, input logic s, input logic w,
                         input logic [3:0] sl, input logic [29:0] a, input logic [31:0] d);
    if (id == 0) begin
      m0__cyc = c; m0__stb = s; m0__we = w; m0__sel = sl; m0__adr = a; m0__dat_w = d;
    end else begin
      m1__cyc = c; m1__stb = s; m1__we = w; m1__sel = sl; m1__adr = a; m1__dat_w = d;
    end
  endtask

  // One strobe. Called at posedge+1. Returns at posedge+1 after the ack.
  // Drops cyc afterwards when last is set.
  task automatic m_txn(input int id, input logic we, input logic [3:0] sel,
                       input logic [29:0] adr, input logic [31:0] dat,
                       input logic last, input logic [31:0] exp_rd);
    int n;
    drive_m(id, 1'b1, 1'b1, we, sel, adr, dat);
    if (id == 0) exp0_q.push_back({we, sel, adr, we ? dat : exp_rd});
    else         exp1_q.push_back({we, sel, adr, we ? dat : exp_rd});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(id) && n < 600);
    if (!ack_of(id)) begin
      chk($sformatf("ack_timeout_m%0d", id), 72'(0), 72'(1));
      if (id == 0) void'(exp0_q.pop_back());
      else         void'(exp1_q.pop_back());
    end
    @(posedge clk);
    #1;
    if (last) drive_m(id, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
  endtask

  task automatic burst(input int id, input int len);
    logic        we;
    logic [29:0] a;
    for (int i = 0; i < len; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 30'($urandom);
      m_txn(id, we, 4'($urandom), a, $urandom, (i == len - 1), rd_data(a));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- monitor: owner model + scoreboard ----------------
  logic [1:0] m_owner = 2'd0;
  logic       m_last  = 1'b1;
  logic       p_rst   = 1'b1;
  logic       p0      = 1'b0;
  logic       p1      = 1'b0;

  always @(negedge clk) begin
    logic        w;
    logic [66:0] e;
    if (p_rst) begin
      m_owner = 2'd0;
      m_last  = 1'b1;
    end else if (m_owner == 2'd0) begin
      if (p0 || p1) begin
        w       = (p0 && p1) ? ~m_last : p1;
        m_owner = w ? 2'd2 : 2'd1;
        m_last  = w;
      end
    end else if (m_owner == 2'd1) begin
      if (!p0) m_owner = 2'd0;
    end else begin
      if (!p1) m_owner = 2'd0;
    end

    chk("owner", 72'(owner), 72'(m_owner));
    if (m_owner == 2'd0) begin
      chk("idle_bus", 72'({bus__cyc, bus__stb, bus__we, bus__adr, bus__sel, bus__dat_w}), 72'(0));
    end else if (!skip_bus) begin
      if (m_owner == 2'd1)
        chk("bus_follow_m0", 72'({bus__cyc, bus__stb, bus__we, bus__adr, bus__sel, bus__dat_w}),
            72'({m0__cyc, m0__stb, m0__we, m0__adr, m0__sel, m0__dat_w}));
      else
        chk("bus_follow_m1", 72'({bus__cyc, bus__stb, bus__we, bus__adr, bus__sel, bus__dat_w}),
            72'({m1__cyc, m1__stb, m1__we, m1__adr, m1__sel, m1__dat_w}));
    end
    if (!skip_bus) chk("dat_r_fwd", 72'({m0__dat_r, m1__dat_r}), 72'({bus__dat_r, bus__dat_r}));
    chk("ack_non_owner", 72'({m0__ack & (m_owner != 2'd1), m1__ack & (m_owner != 2'd2)}), 72'(0));
`ifndef ARB_TIMEOUT_EN
    chk("timeout_flag_tied", 72'(timeout_flag), 72'(0));
`endif

    if (m0__ack) begin
      ack0_cnt++;
      if (exp0_q.size() == 0) chk("unexpected_ack_m0", 72'(1), 72'(0));
      else begin
        e = exp0_q.pop_front();
        chk("sb_m0", 72'({bus__we, bus__sel, bus__adr, e[66] ? bus__dat_w : m0__dat_r}), 72'(e));
      end
    end
    if (m1__ack) begin
      ack1_cnt++;
      if (exp1_q.size() == 0) chk("unexpected_ack_m1", 72'(1), 72'(0));
      else begin
        e = exp1_q.pop_front();
        chk("sb_m1", 72'({bus__we, bus__sel, bus__adr, e[66] ? bus__dat_w : m1__dat_r}), 72'(e));
      end
    end
    p_rst = rst;
    p0    = m0__cyc;
    p1    = m1__cyc;
  end

  // Holds one master in a stalled read, then pulses reset.
  // Afterwards both masters request at once, and m0 must win.
  task automatic reset_mid(input int id);
    int b0, b1;
    slave_mute = 1;
    drive_m(id, 1'b1, 1'b1, 1'b0, 4'hF, 30'h2A, 32'h0);
    repeat (4) @(negedge clk);
    chk($sformatf("rst_mid_owner_before_m%0d", id), 72'(owner), 72'(id + 1));
    b0 = ack0_cnt;
    b1 = ack1_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    drive_m(id, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_after", 72'({owner, bus__cyc, m0__ack, m1__ack}), 72'(0));
    chk("rst_mid_no_ack", 72'({ack0_cnt - b0, ack1_cnt - b1}), 72'(0));
    slave_mute = 0;
    @(posedge clk);
    #1;
    fork
      m_txn(0, 1'b0, 4'hF, 30'h33, 32'h0, 1'b1, rd_data(30'h33));
      m_txn(1, 1'b0, 4'hF, 30'h44, 32'h0, 1'b1, rd_data(30'h44));
      begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_prio_m0", 72'(owner), 72'(1));
      end
    join
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, b1, gaps, first, n;
    bit seen0, seen1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 72'({owner, bus__cyc, bus__stb, m0__ack, m1__ack, timeout_flag}), 72'(0));
    @(posedge clk);
    #1;

    // m0 read at 0x100, two wait states.
    slave_fix = 2;
    b0 = ack0_cnt;
    b1 = ack1_cnt;
    fork
      m_txn(0, 1'b0, 4'hF, 30'h100, 32'h0, 1'b1, 32'hDEAD_BEEF);
      begin
        @(negedge clk);
        chk("m0_read_owner_c0", 72'(owner), 72'(0));
        @(negedge clk);
        chk("m0_read_owner_c1", 72'(owner), 72'(1));
      end
    join
    chk("m0_read_acks", 72'({ack0_cnt - b0, ack1_cnt - b1}), 72'({32'd1, 32'd0}));
    slave_fix = 0;

    // Simultaneous request after reset: m0 first, one IDLE cycle, then m1.
    do_reset();
    gaps  = 0;
    first = 0;
    seen0 = 1'b0;
    seen1 = 1'b0;
    fork
      m_txn(0, 1'b1, 4'h3, 30'h10, 32'h1234_5678, 1'b1, 32'h0);
      m_txn(1, 1'b0, 4'hF, 30'h20, 32'h0, 1'b1, rd_data(30'h20));
      begin
        n = 0;
        while (!seen1 && n < 200) begin
          @(negedge clk);
          n++;
          if (owner != 2'd0 && first == 0) first = int'(owner);
          if (owner == 2'd1) seen0 = 1'b1;
          if (seen0 && owner == 2'd0) gaps++;
          if (owner == 2'd2) seen1 = 1'b1;
        end
      end
    join
    chk("simul_first_m0", 72'(first), 72'(1));
    chk("simul_idle_gap", 72'(gaps), 72'(1));

    // m1 holds cyc for 3 writes while m0 waits: no bus gap, m0 after.
    gaps = 0;
    b1   = ack1_cnt;
    fork
      for (int i = 0; i < 3; i++)
        m_txn(1, 1'b1, 4'hF, 30'(16'h40 + i), 32'(i) ^ 32'hCAFE_0000, (i == 2), 32'h0);
      begin
        @(posedge clk);
        #1;
        m_txn(0, 1'b0, 4'hF, 30'h77, 32'h0, 1'b1, rd_data(30'h77));
      end
      begin
        n = 0;
        while (!m0__ack && n < 200) begin
          @(negedge clk);
          n++;
          if (owner == 2'd2 && m1__cyc && !bus__cyc) gaps++;
          if (m0__ack) chk("hold_m1_done_first", 72'(ack1_cnt - b1), 72'(3));
        end
      end
    join
    chk("hold_no_cyc_gap", 72'(gaps), 72'(0));

    // Reset mid-transfer in GNT1, then in GNT0.
    reset_mid(1);
    reset_mid(0);

    // Random concurrent traffic.
    fork
      for (int k = 0; k < 12; k++) begin
        burst(0, $urandom_range(1, 3));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      for (int k = 0; k < 12; k++) begin
        burst(1, $urandom_range(1, 3));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    join

    // Slave never acks.
    slave_mute = 1;
    b0 = ack0_cnt;
`ifdef ARB_TIMEOUT_EN
    skip_bus = 1'b1;
    fork
      m_txn(0, 1'b0, 4'hF, 30'h55, 32'h0, 1'b1, 32'hFFFF_FFFF);
      begin
        // One request cycle, then wait cycles 1..16. Ack arrives on the 16th.
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m0__ack && n < 100);
        chk("tmo_ack_cycle", 72'(n), 72'(TMO + 2));
        chk("tmo_bus_cyc_low", 72'({bus__cyc, bus__stb}), 72'(0));
        chk("tmo_flag_set", 72'(timeout_flag), 72'(1));
      end
    join
    repeat (5) @(negedge clk);
    chk("tmo_flag_sticky", 72'(timeout_flag), 72'(1));
    skip_bus = 1'b0;
`else
    drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h55, 32'h0);
    repeat (300) @(negedge clk);
    chk("no_tmo_held", 72'({owner, ack0_cnt - b0}), 72'({2'd1, 32'd0}));
    chk("no_tmo_flag", 72'(timeout_flag), 72'(0));
    @(posedge clk);
    #1 drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
`endif
    slave_mute = 0;

    repeat (5) @(negedge clk);
    chk("queues_drained", 72'({exp0_q.size(), exp1_q.size()}), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
